// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scancode receiver.
// Holds the frame FSM encoding, the prefix byte values and the event
// record layout {ext, brk, code} stored in the event FIFO.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
    localparam int         PS2_EV_W    = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // Odd parity over the eight data bits plus the parity bit
    function automatic logic ps2_par_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_scan_rx_if.sv
// ps2_scan_rx_if: valid/ready event stream from the PS/2 receiver to the
// CPU-side consumer, plus the current event FIFO occupancy.
interface ps2_scan_rx_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                              ev_valid;
    logic                              ev_ready;
    logic [7:0]                        ev_code;
    logic                              ev_ext;
    logic                              ev_brk;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   ev_count;

    modport master (
        output ev_valid, ev_code, ev_ext, ev_brk, ev_count,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_code, ev_ext, ev_brk, ev_count,
        output ev_ready
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO for decoded key events. A push into a
// full FIFO is dropped (and flagged on 'drop') unless a pop happens in the
// same cycle, in which case both take effect and the count is held.
// The head output reads as zero while the FIFO is empty.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int WIDTH = PS2_EV_W,
    parameter int DEPTH = 8
) (
    input  logic                           fclk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               din,
    input  logic                           pop,
    output logic [WIDTH-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty,
    output logic                           drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; written only on an accepted push, never reset
    always_ff @(posedge fclk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard receiver. Synchronises the raw PS/2 pins,
// deframes 11-bit frames on ps2_clk falling edges, folds E0/F0 prefixes
// into one event per key and queues events in ps2_event_fifo.
// Optional feature macro: PS2_TIMEOUT_EN adds a watchdog that abandons a
// partial frame after TIMEOUT_CYC fclk cycles without a ps2_clk fall.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_scan_rx_if.master     ev,
    output logic              err_par,
    output logic              err_frm,
    output logic              ovf
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ps2_scan_rx: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("ps2_scan_rx: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("ps2_scan_rx: TIMEOUT_CYC must be at least 2");
    end

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_cur;
    logic                   din;
    logic                   fall;

    ps2_state_t state, state_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [7:0] sh, sh_nx;
    logic       par_ok, par_ok_nx;
    logic       byte_vld, byte_vld_nx;
    logic       err_par_nx;
    logic       err_frm_q, err_frm_nx;
    logic       wd_hit;

    logic       ext_f;
    logic       brk_f;
    logic       push;
    ps2_event_t push_ev;
    ps2_event_t head_ev;
    logic [PS2_EV_W-1:0] fifo_dout;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_drop;

    // Pin synchronisers; idle-high reset so leaving reset never fakes a fall
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_cur = clk_sync[SYNC_STAGES-1];
    assign din     = dat_sync[SYNC_STAGES-1];
    assign fall    = clk_prev & ~clk_cur;

`ifdef PS2_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0] wd;

    // Watchdog: counts idle fclk cycles inside a frame, restarts on each fall
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            wd <= '0;
        end else if (fall || state == IDLE || wd_hit) begin
            wd <= '0;
        end else begin
            wd <= wd + WD_W'(1);
        end
    end

    assign wd_hit = (state != IDLE) && !fall && (wd == WD_W'(TIMEOUT_CYC - 1));
`else
    assign wd_hit = 1'b0;
`endif

    // Frame FSM registers and the one-cycle status pulses
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sh        <= '0;
            par_ok    <= 1'b0;
            byte_vld  <= 1'b0;
            err_par   <= 1'b0;
            err_frm_q <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            sh        <= sh_nx;
            par_ok    <= par_ok_nx;
            byte_vld  <= byte_vld_nx;
            err_par   <= err_par_nx;
            err_frm_q <= err_frm_nx;
        end
    end

    // Frame FSM next state: advances only on a synchronised ps2_clk fall
    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        sh_nx       = sh;
        par_ok_nx   = par_ok;
        byte_vld_nx = 1'b0;
        err_par_nx  = 1'b0;
        err_frm_nx  = 1'b0;
        if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!din) begin
                        state_nx   = DATA;
                        bit_cnt_nx = '0;
                    end
                end
                DATA: begin
                    sh_nx[bit_cnt] = din;
                    if (bit_cnt == 3'd7) begin
                        state_nx = PARITY;
                    end else begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    par_ok_nx = ps2_par_ok(sh, din);
                    state_nx  = STOP;
                end
                STOP: begin
                    byte_vld_nx = din & par_ok;
                    err_frm_nx  = ~din;
                    err_par_nx  = ~par_ok;
                    state_nx    = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end else if (wd_hit) begin
            state_nx = IDLE;
        end
    end

    assign err_frm = err_frm_q | wd_hit;

    // Prefix decoder: E0/F0 set sticky flags that attach to the next real byte
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (wd_hit) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (byte_vld) begin
            if (sh == PS2_PFX_EXT) begin
                ext_f <= 1'b1;
            end else if (sh == PS2_PFX_BRK) begin
                brk_f <= 1'b1;
            end else begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
            end
        end
    end

    assign push         = byte_vld && (sh != PS2_PFX_EXT) && (sh != PS2_PFX_BRK);
    assign push_ev.ext  = ext_f;
    assign push_ev.brk  = brk_f;
    assign push_ev.code = sh;

    ps2_event_fifo #(
        .WIDTH (PS2_EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .fclk  (fclk),
        .rst   (rst),
        .push  (push),
        .din   (push_ev),
        .pop   (ev.ev_ready),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign head_ev     = ps2_event_t'(fifo_dout);
    assign ev.ev_valid = ~fifo_empty;
    assign ev.ev_code  = head_ev.code;
    assign ev.ev_ext   = head_ev.ext;
    assign ev.ev_brk   = head_ev.brk;
    assign ev.ev_count = fifo_count;

    // Overflow flag: sticky once an event is lost, cleared only by reset
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (fifo_drop) begin
            ovf <= 1'b1;
        end
    end

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
